// File: rtl/cog_pkg.sv
// cog_pkg: shared types and width helpers for the CoG frame sequencer.
package cog_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, RESYNC} ctrl_state_t;
    typedef enum logic [1:0] {ERR_NONE, ERR_SHORT, ERR_LONG, ERR_EARLY_SOF} frame_err_t;

    localparam int ERR_W = 2;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cog_xy_counter.sv
// cog_xy_counter: position of the next expected pixel; start loads (1,0) after an accepted SOF.
module cog_xy_counter import cog_pkg::*; #(
    parameter int WIDTH = 10,
    parameter int HEIGHT = 10,
    localparam int XW = cw(WIDTH),
    localparam int YW = cw(HEIGHT)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          clr,
    input  logic          start,
    input  logic          inc,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          x_wrap,
    output logic          y_wrap
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign x_wrap = x_q == XW'(WIDTH - 1);
    assign y_wrap = y_q == YW'(HEIGHT - 1);
    assign x = x_q;
    assign y = y_q;

    always_comb begin
        x_d = clr ? '0 : start ? XW'(1) : inc ? (x_wrap ? '0 : x_q + XW'(1)) : x_q;
        y_d = (clr || start) ? '0 : (inc && x_wrap) ? (y_wrap ? '0 : y_q + YW'(1)) : y_q;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/cog_frame_ctrl.sv
// cog_frame_ctrl: locks onto SOF, checks line/frame structure and forwards only well-formed frames
// to the CoG accumulator with start/done/abort strobes.
module cog_frame_ctrl import cog_pkg::*; #(
    parameter int N = 8,
    parameter int WIDTH = 10,
    parameter int HEIGHT = 10,
    parameter int CNT_W = 8,
    localparam int XW = cw(WIDTH),
    localparam int YW = cw(HEIGHT)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             en,
    input  logic [2*N-1:0]   s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [2*N-1:0]   m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic [XW-1:0]    pix_x,
    output logic [YW-1:0]    pix_y,
    output logic             frame_start,
    output logic             frame_done,
    output logic             frame_abort,
    output logic [ERR_W-1:0] err_code,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    ctrl_state_t      state_q, state_d;
    frame_err_t       err_q, err_d;
    logic [2*N-1:0]   tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [XW-1:0]    pix_x_q, pix_x_d;
    logic [YW-1:0]    pix_y_q, pix_y_d;
    logic             start_q, start_d, done_q, done_d, abort_q, abort_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic             sof, sof_acc, pix_acc;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             x_wrap, y_wrap;

    assign sof = s_axis_tvalid && s_axis_tuser;

    cog_xy_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xy (
        .clk    (clk),
        .areset (areset),
        .clr    (abort_d && !start_d),
        .start  (sof_acc),
        .inc    (pix_acc),
        .x      (x),
        .y      (y),
        .x_wrap (x_wrap),
        .y_wrap (y_wrap)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        abort_d = 1'b0;
        sof_acc = 1'b0;
        pix_acc = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = WAIT_SOF;
            WAIT_SOF, RESYNC: begin
                if (!en && (state_q == WAIT_SOF || sof)) begin
                    state_d = IDLE;
                end else if (sof) begin
                    start_d = 1'b1;
                    if (s_axis_tlast) begin
                        abort_d = 1'b1;
                        err_d   = ERR_SHORT;
                        state_d = RESYNC;
                    end else begin
                        sof_acc = 1'b1;
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: if (s_axis_tvalid) begin
                if (s_axis_tuser) begin
                    // The early SOF beat is itself the start of the next frame.
                    abort_d = 1'b1;
                    err_d   = ERR_EARLY_SOF;
                    start_d = 1'b1;
                    if (s_axis_tlast) state_d = RESYNC;
                    else sof_acc = 1'b1;
                end else if (s_axis_tlast != x_wrap) begin
                    abort_d = 1'b1;
                    err_d   = s_axis_tlast ? ERR_SHORT : ERR_LONG;
                    state_d = RESYNC;
                end else begin
                    pix_acc = 1'b1;
                    if (x_wrap && y_wrap) begin
                        done_d  = 1'b1;
                        state_d = en ? WAIT_SOF : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        tvalid_d    = sof_acc || pix_acc;
        tuser_d     = sof_acc;
        tlast_d     = pix_acc && x_wrap;
        tdata_d     = tvalid_d ? s_axis_tdata : tdata_q;
        pix_x_d     = sof_acc ? '0 : pix_acc ? x : pix_x_q;
        pix_y_d     = sof_acc ? '0 : pix_acc ? y : pix_y_q;
        frame_cnt_d = done_d ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
        err_cnt_d   = (abort_d && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            err_q       <= ERR_NONE;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            start_q     <= start_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign frame_start   = start_q;
    assign frame_done    = done_q;
    assign frame_abort   = abort_q;
    assign err_code      = err_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/cog_frame_ctrl.md
Name: cog_frame_ctrl

Overview:
- Frame-level sequencer between the AXI4-Stream video/mask source (packed {mask, img}, tuser = SOF, tlast = EOL) and the CoG accumulator.
- Locks onto SOF and tracks pixel x/y.
- Validates line length and frame structure, forwards only pixels of well-formed frames, and issues frame_start / frame_done / frame_abort strobes so the accumulator knows when to clear, latch or discard.

Parameters:
- N, 8, bit width of img and of mask; tdata is 2*N bits.
- WIDTH, 10, pixels per line; must be >= 2.
- HEIGHT, 10, lines per frame; must be >= 1.
- CNT_W, 8, width of frame and error counters.

Ports:
- clk  in  1  system clock
- areset  in  1  asynchronous active-high reset
- en  in  1  enable; sampled only in IDLE/WAIT_SOF
- s_axis_tdata  in  2*N  {mask, img}
- s_axis_tvalid  in  1  beat valid; gaps are legal
- s_axis_tlast  in  1  end of line
- s_axis_tuser  in  1  start of frame
- m_axis_tdata  out  2*N  forwarded pixel
- m_axis_tvalid  out  1  forwarded beat valid
- m_axis_tlast  out  1  forwarded end of line
- m_axis_tuser  out  1  forwarded start of frame
- pix_x  out  $clog2(WIDTH)  column of the current m_axis beat
- pix_y  out  $clog2(HEIGHT)  line of the current m_axis beat
- frame_start  out  1  one-cycle pulse, coincident with the m_axis tuser beat
- frame_done  out  1  one-cycle pulse, coincident with the last pixel (x=W-1, y=H-1)
- frame_abort  out  1  one-cycle pulse; accumulator must discard the partial frame
- err_code  out  2  last error: 0 none, 1 short line, 2 long line, 3 early SOF
- frame_cnt  out  CNT_W  completed frames, wraps
- err_cnt  out  CNT_W  aborts, saturates at all-ones

Behaviour:
- Reset (areset=1, asynchronous): state IDLE; all m_axis_* = 0; pix_x = pix_y = 0; all strobes 0; err_code = 0; counters 0. Reset mid-frame drops the frame silently (no abort pulse).
- Latency: all outputs are registered. A beat accepted at edge k appears on m_axis at edge k+1. The input has no tready; every beat is consumed.
- Beats with tvalid=0 are ignored in every state; counters hold.
- Only "accept" beats are forwarded, with m_axis_tvalid=1. Dropped beats give m_axis_tvalid=0.

State machine:
- IDLE: en=1 -> WAIT_SOF. Nothing forwarded.
- WAIT_SOF:
  - en=0 -> IDLE.
  - tvalid & ~tuser -> drop.
  - tvalid & tuser & ~tlast -> accept as (0,0), frame_start, -> ACTIVE.
  - tvalid & tuser & tlast -> short-line error: frame_start and frame_abort in the same cycle, -> RESYNC.
- ACTIVE: on each tvalid beat, evaluate in priority order:
  1. tuser=1: early SOF (err 3). frame_abort; the beat restarts the frame as (0,0) with frame_start in the same output cycle; stay ACTIVE.
  2. tlast=1 and x != W-1: short line (err 1). frame_abort, beat dropped, -> RESYNC.
  3. tlast=0 and x == W-1: long line / missing tlast (err 2). frame_abort, beat dropped, -> RESYNC.
  4. Otherwise accept. When x == W-1, m_axis_tlast=1, x wraps to 0 and y increments.
  5. If the accepted beat has x == W-1 and y == H-1: frame_done, frame_cnt+1, -> WAIT_SOF, or -> IDLE if en=0.
- RESYNC: drop beats until tvalid & tuser, then handle exactly as in WAIT_SOF.
- en deassertion mid-frame: the frame completes normally, then the block goes to IDLE.
- frame_abort always increments err_cnt and updates err_code. err_code holds until the next error; it is not cleared by frame_start.
- frame_done and frame_abort never assert in the same cycle.
- pix_x/pix_y are valid only while m_axis_tvalid=1.

Decomposition:
- Package cog_pkg:
  - ctrl_state_t enum {IDLE, WAIT_SOF, ACTIVE, RESYNC}
  - frame_err_t enum {ERR_NONE, ERR_SHORT, ERR_LONG, ERR_EARLY_SOF}
  - helper width localparams
- Sub-module cog_xy_counter: x/y counter with clear, inc, and wrap flags at W-1 / H-1. Instantiated once.

Test Plan (WIDTH=10, HEIGHT=10, N=8):
1. Clean frame: 100 beats, tuser on beat 0, tlast every 10th, random tvalid gaps -> 100 m_axis beats; frame_start on the first; m_axis_tlast 10x; frame_done on (9,9); frame_cnt=1; err_cnt=0.
2. Short line: tlast on x=7 of line 0 -> frame_abort one cycle after that beat; err_code=1; err_cnt=1; further beats dropped until the next tuser; next clean frame -> frame_done, frame_cnt=1.
3. Missing tlast: line 0 x=9 with tlast=0 -> frame_abort; err_code=2; nothing forwarded until the next SOF.
4. Early SOF at line 4, x=3 -> frame_abort and frame_start in the same cycle; pix_x=pix_y=0; err_code=3; the new frame completes -> frame_done.
5. Pre-SOF garbage and en: 15 beats without tuser while in WAIT_SOF -> m_axis_tvalid stays 0. Drop en at line 5 -> the frame still completes, then IDLE; a following tuser is ignored.
6. Reset mid-frame: areset at line 3 -> all outputs 0 immediately (asynchronous), no frame_abort; after release with en=1, the next SOF is accepted normally.
